// File: rtl/fetch_stage.sv
// fetch_stage: IF stage owning the PC, fetching over a valid/ready imem with a skid slot.
// Optional perf counters (fetch_count, bubble_count) when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output logic [31:0]      pc4,
  output logic [31:0]      instruction,
  output logic             inst_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] fetch_count,
  output logic [CNT_W-1:0] bubble_count
`endif
);

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    DISCARD
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:2] pc;
  logic [31:2] req_addr;
  logic        out_v;
  logic [31:0] out_pc4;
  logic [31:0] out_ins;
  logic        skid_v;
  logic [31:0] skid_pc4;
  logic [31:0] skid_ins;
  logic        consume;
  logic        accept;
  logic        rsp;
  logic [1:0]  held;
  logic [31:0] new_pc4;
  logic        unused_ok;

  assign consume = out_v & ~stall;
  // words still held after this edge; the new request will need one more slot
  assign held    = {1'b0, out_v} + {1'b0, skid_v} - {1'b0, consume};
  assign imem_req  = (state == FETCH) & (held < 2'd2) & ~reset;
  assign imem_addr = {pc, 2'b00};
  assign accept  = imem_req & imem_ready;
  assign rsp     = imem_rvalid & (state == WAIT);
  assign new_pc4 = {req_addr + 30'd1, 2'b00};

  assign pc4         = out_pc4;
  assign instruction = out_v ? out_ins : NOP_INSTR;
  assign inst_valid  = out_v;

  always_comb begin
    state_nx = state;
    unique case (state)
      FETCH:   if (accept) state_nx = WAIT;
      WAIT:    if (imem_rvalid) state_nx = FETCH;
      DISCARD: if (imem_rvalid) state_nx = FETCH;
      default: state_nx = FETCH;
    endcase
    if (redirect && (accept || (state == WAIT && !imem_rvalid)))
      state_nx = DISCARD;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      pc       <= RESET_PC[31:2];
      req_addr <= '0;
      out_v    <= 1'b0;
      out_pc4  <= '0;
      out_ins  <= '0;
      skid_v   <= 1'b0;
      skid_pc4 <= '0;
      skid_ins <= '0;
    end else begin
      state <= state_nx;
      if (redirect) begin
        pc     <= redirect_pc[31:2];
        out_v  <= 1'b0;
        skid_v <= 1'b0;
      end else begin
        if (accept) begin
          pc       <= pc + 30'd1;
          req_addr <= pc;
        end
        if (rsp && (!out_v || (consume && !skid_v))) begin
          out_v   <= 1'b1;
          out_pc4 <= new_pc4;
          out_ins <= imem_rdata;
        end else if (consume && skid_v) begin
          out_pc4 <= skid_pc4;
          out_ins <= skid_ins;
        end else if (consume) begin
          out_v <= 1'b0;
        end
        if (rsp && out_v && (skid_v || !consume)) begin
          skid_v   <= 1'b1;
          skid_pc4 <= new_pc4;
          skid_ins <= imem_rdata;
        end else if (consume) begin
          skid_v <= 1'b0;
        end
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count  <= '0;
      bubble_count <= '0;
    end else begin
      if (consume)
        fetch_count <= fetch_count + 1'b1;
      if (!out_v && !stall)
        bubble_count <= bubble_count + 1'b1;
    end
  end

  assign unused_ok = ^redirect_pc[1:0];
`else
  assign unused_ok = ^{redirect_pc[1:0], CNT_W != 0};
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: random + scenario stimulus against a queue-based fetch model.
// Define FETCH_PERF_CNT_EN to also check the perf counters.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc4;
  logic [31:0] instruction;
  logic        inst_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;
`endif

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP),
    .CNT_W    (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc4         (pc4),
    .instruction (instruction),
    .inst_valid  (inst_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count (fetch_count),
    .bubble_count(bubble_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] ins;
  } ent_t;

  // model: words fetched but not consumed, next pc, one outstanding request
  ent_t        q[$];
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  bit          m_out;
  bit          m_drop;
  logic [31:0] m_fc;
  logic [31:0] m_bc;

  bit          im_pend;
  int          im_lat;
  logic [31:0] im_addr;
  int          lat_lo;
  int          lat_hi;

  int n_tests;
  int n_fail;
  bit found;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F17;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit st, input bit rd,
                      input logic [31:0] rpc, input bit rdy);
    bit cons;
    bit exp_req;
    bit acc;
    bit rsp;
    bit dut_acc;
    int n;
    reset       = r;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    imem_ready  = rdy;
    imem_rvalid = im_pend && im_lat == 0;
    imem_rdata  = imem_rvalid ? mem_word(im_addr) : $urandom;
    @(negedge clk);
    n       = q.size();
    cons    = n > 0 && !st;
    exp_req = !r && !m_out && (n - (cons ? 1 : 0)) <= 1;
    chk("imem_req", imem_req, exp_req);
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    chk("inst_valid", inst_valid, n > 0);
    chk("instruction", instruction, n > 0 ? q[0].ins : NOP);
    if (n > 0) chk("pc4", pc4, q[0].pc4);
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_count", fetch_count, m_fc);
    chk("bubble_count", bubble_count, m_bc);
`endif
    dut_acc = imem_req && imem_ready;
    @(posedge clk);
    acc = exp_req && rdy;
    rsp = imem_rvalid && m_out;
    if (r) begin
      q.delete();
      m_pc   = 32'h0;
      m_out  = 0;
      m_drop = 0;
      m_fc   = 0;
      m_bc   = 0;
    end else begin
      if (cons) m_fc++;
      if (n == 0 && !st) m_bc++;
      if (rd) begin
        q.delete();
        if (acc) begin
          m_out  = 1;
          m_drop = 1;
        end else if (rsp) begin
          m_out  = 0;
          m_drop = 0;
        end else if (m_out) begin
          m_drop = 1;
        end
        m_pc = rpc & ~32'h3;
      end else begin
        if (cons) void'(q.pop_front());
        if (rsp) begin
          if (!m_drop)
            q.push_back('{pc4: m_addr + 32'd4, ins: mem_word(m_addr)});
          m_out  = 0;
          m_drop = 0;
        end
        if (acc) begin
          m_out  = 1;
          m_drop = 0;
          m_addr = m_pc;
          m_pc   = m_pc + 32'd4;
        end
      end
    end
    if (r) begin
      im_pend = 0;
    end else begin
      if (imem_rvalid) im_pend = 0;
      else if (im_pend) im_lat--;
      if (dut_acc) begin
        im_pend = 1;
        im_addr = imem_addr;
        im_lat  = $urandom_range(lat_hi, lat_lo);
      end
    end
    #1;
  endtask

  task automatic run(input int cycles, input bit st);
    for (int i = 0; i < cycles; i++) step(0, st, 0, 32'h0, 1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    im_pend = 0;
    im_lat  = 0;
    im_addr = 0;
    m_pc    = 0;
    m_addr  = 0;
    m_out   = 0;
    m_drop  = 0;
    m_fc    = 0;
    m_bc    = 0;
    lat_lo  = 0;
    lat_hi  = 0;
    reset = 1; stall = 0; redirect = 0; redirect_pc = 0;
    imem_ready = 1; imem_rvalid = 0; imem_rdata = 0;
    @(posedge clk);
    #1;

    // latency 1, no stall
    step(1, 0, 0, 32'h0, 1);
    step(1, 0, 0, 32'h0, 1);
    chk("rst_pc4", pc4, 32'h0);
    run(20, 0);

    // latency 3, stall after first word
    lat_lo = 2; lat_hi = 2;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (q.size() > 0) found = 1;
      else step(0, 0, 0, 32'h0, 1);
    end
    chk("s2_first_word", found, 1);
    run(6, 1);
    chk("s2_req_held", imem_req, 1'b0);
    run(12, 0);

    // redirect while waiting (response not yet back)
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_out && im_pend && im_lat != 0) begin
        step(0, 0, 1, 32'h100, 1);
        found = 1;
      end else step(0, 0, 0, 32'h0, 1);
    end
    chk("s3_hit", found, 1);
    lat_lo = 0; lat_hi = 0;
    run(10, 0);

    // redirect in the same cycle as rvalid
    lat_lo = 1; lat_hi = 1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_out && im_pend && im_lat == 0) begin
        step(0, 0, 1, 32'h100, 1);
        found = 1;
      end else step(0, 0, 0, 32'h0, 1);
    end
    chk("s4_hit", found, 1);
    run(10, 0);

    // redirect and stall together
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (q.size() > 0) begin
        step(0, 1, 1, 32'h200, 1);
        found = 1;
      end else step(0, 1, 0, 32'h0, 1);
    end
    chk("s5_hit", found, 1);
    run(3, 1);
    run(8, 0);

    // PC wrap and unaligned redirect target
    lat_lo = 0; lat_hi = 0;
    step(0, 0, 1, 32'hFFFF_FFFC, 1);
    run(8, 0);
    step(0, 0, 1, 32'h0000_0103, 1);
    run(8, 0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] rpc;
      if (i % 100 == 0) begin
        lat_lo = 0;
        lat_hi = $urandom_range(3, 0);
      end
      rpc = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFF8 + $urandom_range(7, 0)
                                         : $urandom;
      step($urandom_range(299, 0) == 0, $urandom_range(3, 0) == 0,
           $urandom_range(15, 0) == 0, rpc, $urandom_range(2, 0) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
